// File: rtl/hdu_multicycle.sv
// Hazard detection unit for a pipeline with a multi-cycle data memory.
// It handles load-use stalls of LOAD_LAT cycles, a memory-busy freeze, the branch IF flush and a saturating stall counter.
module hdu_multicycle #(
    parameter int ADDR_W      = 5,
    parameter int LOAD_LAT    = 1,
    parameter int CNT_W       = 16,
    parameter int ZERO_BYPASS = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] ID_RS1addr_i,
    input  logic [ADDR_W-1:0] ID_RS2addr_i,
    input  logic              ID_RS1use_i,
    input  logic              ID_RS2use_i,
    input  logic [ADDR_W-1:0] EX_RDaddr_i,
    input  logic              EX_MemRead_i,
    input  logic              Branch_taken_i,
    input  logic              Mem_busy_i,
    output logic              select_o,
    output logic              PCWrite_o,
    output logic              IF_ID_write_o,
    output logic              IF_flush_o,
    output logic              Pipe_stall_o,
    output logic [CNT_W-1:0]  Stall_cnt_o
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_STALL = 1'b1;
    localparam logic [2:0] LAT_M1   = 3'(LOAD_LAT - 1);
    localparam logic       ZB       = (ZERO_BYPASS != 0);

    generate
        if (LOAD_LAT < 1 || LOAD_LAT > 7) begin : g_bad_lat
            $fatal(1, "hdu_multicycle: LOAD_LAT must be within 1..7");
        end
    endgenerate

    logic [0:0]       r_state;
    logic [2:0]       r_rem;
    logic [CNT_W-1:0] r_cnt;

    logic [0:0]       w_state_nxt;
    logic [2:0]       w_rem_nxt;
    logic             w_rs1_hz;
    logic             w_rs2_hz;
    logic             w_hz;
    logic             w_stall_cyc;

    // A source equal to register 0 never creates a hazard when ZERO_BYPASS is set.
    assign w_rs1_hz = ID_RS1use_i && (EX_RDaddr_i == ID_RS1addr_i)
                      && !(ZB && (ID_RS1addr_i == {ADDR_W{1'b0}}));
    assign w_rs2_hz = ID_RS2use_i && (EX_RDaddr_i == ID_RS2addr_i)
                      && !(ZB && (ID_RS2addr_i == {ADDR_W{1'b0}}));
    assign w_hz     = EX_MemRead_i && (w_rs1_hz || w_rs2_hz);

    assign w_stall_cyc = !rst_i && (Mem_busy_i || (r_state == ST_STALL) || w_hz);

    // Pipeline control decode, in priority order: reset, freeze, load-use stall, then normal flow or flush.
    always_comb begin
        select_o      = 1'b0;
        PCWrite_o     = 1'b0;
        IF_ID_write_o = 1'b0;
        IF_flush_o    = 1'b0;
        Pipe_stall_o  = 1'b0;
        if (rst_i) begin
            Pipe_stall_o = 1'b0;
        end else if (Mem_busy_i) begin
            Pipe_stall_o = 1'b1;
        end else if ((r_state == ST_STALL) || w_hz) begin
            select_o = 1'b1;
        end else begin
            PCWrite_o     = 1'b1;
            IF_ID_write_o = 1'b1;
            IF_flush_o    = Branch_taken_i;
        end
    end

    // Next state and remaining-cycle count; a frozen cycle holds both.
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        if (!Mem_busy_i) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hz && (LOAD_LAT > 1)) begin
                        w_state_nxt = ST_STALL;
                        w_rem_nxt   = LAT_M1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_rem_nxt   = 3'd0;
                    end
                end
                ST_STALL: begin
                    if (r_rem <= 3'd1) begin
                        w_state_nxt = ST_IDLE;
                        w_rem_nxt   = 3'd0;
                    end else begin
                        w_state_nxt = ST_STALL;
                        w_rem_nxt   = r_rem - 3'd1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_rem_nxt   = 3'd0;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
            w_rem_nxt   = r_rem;
        end
    end

    // State registers and the saturating stall counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_rem   <= 3'd0;
            r_cnt   <= {CNT_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            if (w_stall_cyc && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    assign Stall_cnt_o = r_cnt;

endmodule

// File: doc/hdu_multicycle.md
Name: hdu_multicycle

Overview:
- Parametrised successor to the pipeline hazard detection unit.
- Detects load-use hazards and holds the stall for a configurable number of bubble cycles (LOAD_LAT), so a multi-cycle data memory can be tolerated.
- Adds a global freeze on a data-memory busy signal, a branch-taken IF flush, x0 exclusion and per-operand use qualification.
- Adds a saturating stall-cycle performance counter.
- Sits between ID and EX; drives the PC, IF/ID register, ID/EX bubble mux and the pipeline freeze.

Parameters:
ADDR_W  5  register address width
LOAD_LAT  1  bubble cycles per load-use hazard; legal range 1..7
CNT_W  16  width of stall performance counter
ZERO_BYPASS  1  1: sources equal to register 0 never cause a hazard

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
ID_RS1addr_i  in  ADDR_W  rs1 of instruction in ID
ID_RS2addr_i  in  ADDR_W  rs2 of instruction in ID
ID_RS1use_i  in  1  ID instruction reads rs1
ID_RS2use_i  in  1  ID instruction reads rs2
EX_RDaddr_i  in  ADDR_W  rd of instruction in EX
EX_MemRead_i  in  1  EX instruction is a load
Branch_taken_i  in  1  branch in ID resolved taken
Mem_busy_i  in  1  data memory not ready; freeze pipeline
select_o  out  1  1: force ID/EX control to bubble
PCWrite_o  out  1  1: PC may update
IF_ID_write_o  out  1  1: IF/ID may update
IF_flush_o  out  1  1: zero the IF/ID instruction
Pipe_stall_o  out  1  1: freeze all pipeline registers
Stall_cnt_o  out  CNT_W  total stall cycles since reset, saturating

Behaviour:
- Hazard condition: hz = EX_MemRead_i & ((ID_RS1use_i & EX_RDaddr_i==ID_RS1addr_i & !(ZERO_BYPASS & ID_RS1addr_i==0)) | (same term for RS2)).
- State machine, two states: IDLE and LU_STALL. It carries a remaining-cycle counter rem, width 3.
- Priority, highest first: rst_i, Mem_busy_i, load-use stall, flush.
- rst_i=1 (sampled at the clock edge):
  - next state IDLE; rem=0; Stall_cnt_o=0.
  - Outputs while rst_i is high: select_o=0, PCWrite_o=0, IF_ID_write_o=0, IF_flush_o=0, Pipe_stall_o=0.
- Mem_busy_i=1:
  - Pipe_stall_o=1, PCWrite_o=0, IF_ID_write_o=0, select_o=0, IF_flush_o=0.
  - State and rem hold, and hz is not evaluated.
  - Stall_cnt_o increments.
- IDLE, hz=1:
  - Combinational, same cycle: select_o=1, PCWrite_o=0, IF_ID_write_o=0, IF_flush_o=0.
  - If LOAD_LAT>1: next state LU_STALL with rem=LOAD_LAT-1. Otherwise stay in IDLE.
  - Stall_cnt_o increments.
- LU_STALL:
  - select_o=1, PCWrite_o=0, IF_ID_write_o=0, IF_flush_o=0, regardless of hz. The EX stage now holds a bubble.
  - rem decrements each non-frozen cycle. When rem==1, next state is IDLE.
  - Stall_cnt_o increments.
- Total load-use stall length: exactly LOAD_LAT non-frozen cycles per hazard, with any Mem_busy_i cycles added on top.
- IDLE, hz=0:
  - select_o=0, PCWrite_o=1, IF_ID_write_o=1, Pipe_stall_o=0.
  - IF_flush_o = Branch_taken_i.
- Branch_taken_i during a stall or a freeze is ignored. The branch re-evaluates once its operands are available.
- Back-to-back hazards: a new hz in the first IDLE cycle after LU_STALL starts a fresh stall with no gap cycle.
- Stall_cnt_o saturates at 2^CNT_W-1 and does not wrap.
- Reset asserted mid-stall aborts the stall immediately. The first post-reset cycle is IDLE.
- LOAD_LAT outside 1..7 is a fatal elaboration error.

Test Plan:
- No hazard, LOAD_LAT=1: EX_MemRead_i=1, EX_RD=5, ID rs1=6, rs2=7 (both used) -> select_o=0, PCWrite_o=1 every cycle; Stall_cnt_o stays 0.
- Load-use, LOAD_LAT=1: EX_RD=5, ID rs1=5 used -> select_o=1, PCWrite_o=0 for exactly 1 cycle; next cycle (EX bubble) back to normal; Stall_cnt_o=1.
- LOAD_LAT=3, rs2 match on 9 -> stall 3 consecutive cycles, then release; Mem_busy_i pulsed for 2 cycles during cycle 2 -> Pipe_stall_o=1 for those 2 cycles; total 5 stall cycles; Stall_cnt_o=5.
- Exclusions: EX_RD=0 with rs1=0 (ZERO_BYPASS=1) -> no stall. rs1=5 matching but ID_RS1use_i=0 -> no stall. Branch_taken_i=1 during that no-stall cycle -> IF_flush_o=1 for 1 cycle.
- Branch_taken_i=1 together with a hazard -> IF_flush_o=0, select_o=1. Reset asserted in LU_STALL with rem=2 -> next cycle IDLE, all counters 0.
- CNT_W=4: force 20 stall cycles -> Stall_cnt_o saturates at 15.
